// File: rtl/rx_pkg.sv
// Shared UART definitions: default frame geometry and receiver state encoding.
// The transmitter imports the same package so both ends agree on framing.
package rx_pkg;

  localparam int WIDTH_WORD_DEF = 8;
  localparam int BIT_STOP_DEF   = 2;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level; resets to the idle-high value.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx.sv
// Oversampling UART receiver: start-bit validation at mid-bit, LSB-first data,
// stop-bit framing check, one-cycle done pulse with held data/error outputs.
module rx
  import rx_pkg::*;
#(
  parameter int WIDTH_WORD_RX = WIDTH_WORD_DEF,
  parameter int CANT_BIT_STOP = BIT_STOP_DEF,
  parameter int OVERSAMPLE    = OVERSAMPLE_DEF
) (
  input  logic                     i_rate,
  input  logic                     i_reset,
  input  logic                     i_bit_rx,
  output logic [WIDTH_WORD_RX-1:0] o_data_out,
  output logic                     o_rx_done,
  output logic                     o_frame_error
);

  localparam int TW       = cnt_width(OVERSAMPLE);
  localparam int BITS_MAX = max_int(WIDTH_WORD_RX, CANT_BIT_STOP);
  localparam int BW       = cnt_width(BITS_MAX);

  localparam logic [TW-1:0] TICK_HALF      = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST      = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_DATA_LAST  = BW'(WIDTH_WORD_RX - 1);
  localparam logic [BW-1:0] BIT_STOP_LAST  = BW'(CANT_BIT_STOP - 1);

  logic line;

  sync_2ff u_sync (
    .clk   (i_rate),
    .rst_n (i_reset),
    .d     (i_bit_rx),
    .q     (line)
  );

  rx_state_e                state_q, state_d;
  logic [TW-1:0]            tick_q, tick_d;
  logic [BW-1:0]            bit_q, bit_d;
  logic [WIDTH_WORD_RX-1:0] shift_q, shift_d;
  logic                     err_q, err_d;
  logic                     armed_q, armed_d;
  logic                     pend_q, pend_d;
  logic [WIDTH_WORD_RX-1:0] data_q, data_d;
  logic                     done_q, done_d;
  logic                     ferr_q, ferr_d;

  always_ff @(posedge i_rate or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      err_q   <= err_d;
      armed_q <= armed_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    err_d   = err_q;
    armed_d = armed_q;
    pend_d  = 1'b0;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;

    // Publish one edge after the last stop sample, independent of the FSM.
    if (pend_q) begin
      data_d = shift_q;
      ferr_d = err_q;
      done_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        // armed requires the line seen high in idle, so a break cannot retrigger.
        if (line) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_START;
          armed_d = 1'b0;
        end
      end
      ST_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d = '0;
          bit_d  = '0;
          if (!line) begin
            state_d = ST_DATA;
            err_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = {line, shift_q[WIDTH_WORD_RX-1:1]};
          if (bit_q == BIT_DATA_LAST) begin
            state_d = ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (!line) err_d = 1'b1;
          if (bit_q == BIT_STOP_LAST) begin
            state_d = ST_IDLE;
            bit_d   = '0;
            pend_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_data_out    = data_q;
  assign o_rx_done     = done_q;
  assign o_frame_error = ferr_q;

endmodule

// File: tb/tb_rx.sv
// Directed and randomized frames against a bit-level line model of the receiver.
module tb_rx;

  localparam int W   = 8;
  localparam int S   = 2;
  localparam int OS  = 16;
  // 2 sync edges + 1 detect edge + half bit + full data/stop bits + 1 publish edge
  localparam int LAT   = 3 + OS / 2 + OS * (W + S);
  localparam int FRAME = OS * (1 + W + S);

  logic         rate;
  logic         reset_n;
  logic         bit_rx;
  logic [W-1:0] data_out;
  logic         rx_done;
  logic         frame_error;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int           rec_cyc[$];
  logic [W-1:0] rec_data[$];
  logic         rec_err[$];

  rx #(
    .WIDTH_WORD_RX (W),
    .CANT_BIT_STOP (S),
    .OVERSAMPLE    (OS)
  ) dut (
    .i_rate        (rate),
    .i_reset       (reset_n),
    .i_bit_rx      (bit_rx),
    .o_data_out    (data_out),
    .o_rx_done     (rx_done),
    .o_frame_error (frame_error)
  );

  initial rate = 1'b0;
  always #5 rate = ~rate;

  always @(posedge rate) cyc <= cyc + 1;

  always @(negedge rate) begin
    if (rx_done) begin
      rec_cyc.push_back(cyc);
      rec_data.push_back(data_out);
      rec_err.push_back(frame_error);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    bit_rx = b;
    repeat (OS) @(negedge rate);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic [S-1:0] stops, output int start_cyc);
    start_cyc = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < W; i++) drive_bit(d[i]);
    for (int i = 0; i < S; i++) drive_bit(stops[i]);
  endtask

  task automatic idle_high(input int n);
    bit_rx = 1'b1;
    repeat (n) @(negedge rate);
  endtask

  task automatic flush_records();
    while (rec_cyc.size() > 0) begin
      void'(rec_cyc.pop_front());
      void'(rec_data.pop_front());
      void'(rec_err.pop_front());
    end
  endtask

  task automatic expect_frame(input string tag, input logic [W-1:0] d, input logic e,
                              input int start_cyc, output int done_cyc);
    int c;
    logic [W-1:0] rd;
    logic re;
    done_cyc = -1;
    chk({tag, " pulses"}, rec_cyc.size(), 1);
    if (rec_cyc.size() > 0) begin
      c  = rec_cyc.pop_front();
      rd = rec_data.pop_front();
      re = rec_err.pop_front();
      done_cyc = c;
      chk({tag, " latency"}, c - start_cyc, LAT);
      chk({tag, " data"}, rd, d);
      chk({tag, " ferr"}, re, e);
    end
    flush_records();
    chk({tag, " held"}, data_out, d);
  endtask

  initial begin
    int s0, s1, d0, d1;
    logic [W-1:0] rd;
    logic [S-1:0] rs;

    reset_n = 1'b0;
    bit_rx  = 1'b1;
    repeat (3) @(negedge rate);
    chk("reset data", data_out, 0);
    chk("reset done", rx_done, 0);
    chk("reset ferr", frame_error, 0);
    reset_n = 1'b1;
    idle_high(20);

    send_frame(8'h96, '1, s0);
    expect_frame("f96", 8'h96, 1'b0, s0, d0);
    chk("f96 ferr out", frame_error, 0);

    send_frame(8'h86, 2'b01, s0);
    expect_frame("f86", 8'h86, 1'b1, s0, d0);
    repeat (80) @(negedge rate);
    chk("break no pulse", rec_cyc.size(), 0);
    idle_high(40);
    chk("break recover no pulse", rec_cyc.size(), 0);
    chk("break ferr held", frame_error, 1);

    bit_rx = 1'b0;
    repeat (4) @(negedge rate);
    idle_high(60);
    chk("glitch no pulse", rec_cyc.size(), 0);
    chk("glitch data held", data_out, 8'h86);

    s0 = cyc + 1;
    drive_bit(1'b0);
    rd = 8'h3C;
    for (int i = 0; i < 4; i++) drive_bit(rd[i]);
    bit_rx = rd[4];
    repeat (5) @(negedge rate);
    reset_n = 1'b0;
    bit_rx  = 1'b1;
    @(negedge rate);
    chk("midreset data", data_out, 0);
    chk("midreset ferr", frame_error, 0);
    repeat (99) @(negedge rate);
    reset_n = 1'b1;
    idle_high(300);
    chk("midreset no pulse", rec_cyc.size(), 0);
    chk("midreset data after", data_out, 0);
    send_frame(8'h5A, '1, s0);
    expect_frame("f5a", 8'h5A, 1'b0, s0, d0);
    idle_high(5);

    send_frame(8'h00, '1, s0);
    send_frame(8'hFF, '1, s1);
    chk("b2b pulses", rec_cyc.size(), 2);
    if (rec_cyc.size() == 2) begin
      chk("b2b gap", rec_cyc[1] - rec_cyc[0], FRAME);
      chk("b2b first lat", rec_cyc[0] - s0, LAT);
      chk("b2b first data", rec_data[0], 8'h00);
      chk("b2b second data", rec_data[1], 8'hFF);
    end
    flush_records();

    for (int n = 0; n < 20; n++) begin
      idle_high($urandom_range(1, 20));
      rd = W'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? S'($urandom) : '1;
      send_frame(rd, rs, s0);
      expect_frame($sformatf("rnd%0d", n), rd, (rs != '1), s0, d0);
    end
    idle_high(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
